// File: rtl/slot_reel_if.sv
// Control/status bundle between the game logic (RNG, keypad, bet) and the reel engine.
interface slot_reel_if #(
    parameter int unsigned N_REELS = 4,
    parameter int unsigned SYM_W   = 4,
    parameter int unsigned BAL_W   = 16
);
    logic                     roll;
    logic                     stop;
    logic [BAL_W-1:0]         bet;
    logic [N_REELS*SYM_W-1:0] rng_in;
    logic [N_REELS*SYM_W-1:0] digits;
    logic [BAL_W-1:0]         balance;
    logic                     busy;
    logic [N_REELS-1:0]       wild_active;
    logic                     payout_valid;
    logic                     bet_err;
    logic                     game_win;
    logic                     game_loss;

    modport master (
        output roll, stop, bet, rng_in,
        input  digits, balance, busy, wild_active, payout_valid, bet_err, game_win, game_loss
    );
    modport slave (
        input  roll, stop, bet, rng_in,
        output digits, balance, busy, wild_active, payout_valid, bet_err, game_win, game_loss
    );
endinterface

// File: rtl/slot_reel_engine.sv
// Slot-machine core: staggered reel stops, player-stopped wildcards, match-count payout
// and sticky win/loss tracking of the balance.
module slot_reel_engine #(
    parameter int unsigned N_REELS        = 4,
    parameter int unsigned SYM_W          = 4,
    parameter int unsigned N_SYMBOLS      = 10,
    parameter int unsigned WILD_CODE      = 10,
    parameter int unsigned SPIN_CYCLES    = 300000000,
    parameter int unsigned STAGGER_CYCLES = 50000000,
    parameter int unsigned STEP_CYCLES    = 10000000,
    parameter int unsigned BAL_W          = 16,
    parameter int unsigned BAL_INIT       = 1000,
    parameter int unsigned WIN_THRESH     = 1500,
    parameter int unsigned LOSS_THRESH    = 500,
    parameter int unsigned PAY2           = 2,
    parameter int unsigned PAY3           = 7,
    parameter int unsigned PAYALL         = 15
) (
    input  logic       clk,
    input  logic       rst,
    slot_reel_if.slave bus
);
    localparam int unsigned LAST_LOCK = SPIN_CYCLES + (N_REELS - 1) * STAGGER_CYCLES;
    localparam int unsigned CNT_W     = $clog2(LAST_LOCK + 2);
    localparam int unsigned STEP_MAX  = STEP_CYCLES + (N_REELS - 1) * (STEP_CYCLES / 4);
    localparam int unsigned STEP_W    = $clog2(STEP_MAX + 1);
    localparam int unsigned K_W       = $clog2(N_REELS + 1);
    localparam int unsigned PW        = BAL_W + 8;

    typedef enum logic [2:0] {S_IDLE, S_SPIN, S_WILD, S_SCORE, S_OVER} state_t;

    state_t                              state_q, state_n;
    logic [CNT_W-1:0]                    cnt_q, cnt_n;
    logic [N_REELS-1:0][STEP_W-1:0]      step_q, step_n;
    logic [STEP_W-1:0]                   wcnt_q, wcnt_n;
    logic [N_REELS-1:0][SYM_W-1:0]       dig_q, dig_n, snap_q, snap_n;
    logic [BAL_W-1:0]                    bet_q, bet_n, bal_q, bal_n;
    logic [N_REELS-1:0]                  locked_q, locked_n, wild_q, wild_n, wact_q, wact_n;
    logic                                pv_q, pv_n, err_q, err_n, win_q, win_n;
    logic                                loss_q, loss_n, busy_q, busy_n;
    logic [K_W-1:0]                      kmax, cnt_eq;
    logic [PW-1:0]                       sum, mult;

    function automatic logic [SYM_W-1:0] next_sym(input logic [SYM_W-1:0] d);
        return (32'(d) >= N_SYMBOLS - 1) ? '0 : d + SYM_W'(1);
    endfunction

    // Largest number of reels showing the same digit.
    always_comb begin
        kmax   = '0;
        cnt_eq = '0;
        for (int i = 0; i < N_REELS; i++) begin
            cnt_eq = '0;
            for (int j = 0; j < N_REELS; j++)
                if (dig_q[j] == dig_q[i]) cnt_eq = cnt_eq + K_W'(1);
            if (cnt_eq > kmax) kmax = cnt_eq;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        step_n   = step_q;
        wcnt_n   = wcnt_q;
        dig_n    = dig_q;
        snap_n   = snap_q;
        bet_n    = bet_q;
        bal_n    = bal_q;
        locked_n = locked_q;
        wild_n   = wild_q;
        wact_n   = wact_q;
        pv_n     = 1'b0;
        err_n    = 1'b0;
        win_n    = win_q;
        loss_n   = loss_q;
        sum      = '0;
        mult     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.roll) begin
                    if (bus.bet != '0 && bus.bet <= bal_q) begin
                        state_n  = S_SPIN;
                        bet_n    = bus.bet;
                        snap_n   = bus.rng_in;
                        cnt_n    = '0;
                        step_n   = '0;
                        locked_n = '0;
                        wild_n   = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_SPIN: begin
                cnt_n = cnt_q + CNT_W'(1);
                // Each reel either locks on its own cycle or keeps animating at its own rate.
                for (int i = 0; i < N_REELS; i++) begin
                    if (!locked_q[i]) begin
                        if (cnt_q == CNT_W'(SPIN_CYCLES + i * STAGGER_CYCLES)) begin
                            locked_n[i] = 1'b1;
                            if (32'(snap_q[i]) == WILD_CODE || 32'(snap_q[i]) >= N_SYMBOLS) begin
                                wild_n[i] = 1'b1;
                                dig_n[i]  = '0;
                            end else begin
                                dig_n[i] = snap_q[i];
                            end
                        end else if (step_q[i] == STEP_W'(STEP_CYCLES + i * (STEP_CYCLES / 4) - 1)) begin
                            step_n[i] = '0;
                            dig_n[i]  = next_sym(dig_q[i]);
                        end else begin
                            step_n[i] = step_q[i] + STEP_W'(1);
                        end
                    end
                end
                if (cnt_q == CNT_W'(LAST_LOCK)) begin
                    if (wild_n != '0) begin
                        state_n = S_WILD;
                        wact_n  = wild_n & (~wild_n + N_REELS'(1));
                        wcnt_n  = '0;
                    end else begin
                        state_n = S_SCORE;
                    end
                end
            end
            S_WILD: begin
                for (int i = 0; i < N_REELS; i++)
                    if (wact_q[i] && !bus.stop && wcnt_q == STEP_W'(STEP_CYCLES - 1))
                        dig_n[i] = next_sym(dig_q[i]);
                if (bus.stop) begin
                    wild_n = wild_q & ~wact_q;
                    wact_n = wild_n & (~wild_n + N_REELS'(1));
                    wcnt_n = '0;
                    if (wild_n == '0) state_n = S_SCORE;
                end else begin
                    wcnt_n = (wcnt_q == STEP_W'(STEP_CYCLES - 1)) ? '0 : wcnt_q + STEP_W'(1);
                end
            end
            S_SCORE: begin
                pv_n = 1'b1;
                if (kmax <= K_W'(1)) begin
                    bal_n = bal_q - bet_q;
                end else begin
                    mult  = (kmax == K_W'(N_REELS)) ? PW'(PAYALL) :
                            (kmax >= K_W'(3))       ? PW'(PAY3)   : PW'(PAY2);
                    sum   = PW'(bal_q) + PW'(bet_q) * mult;
                    bal_n = (sum[PW-1:BAL_W] != '0) ? '1 : sum[BAL_W-1:0];
                end
                if (bal_n >= BAL_W'(WIN_THRESH)) begin
                    state_n = S_OVER;
                    win_n   = 1'b1;
                    for (int i = 0; i < N_REELS; i++) dig_n[i] = SYM_W'(N_SYMBOLS - 1);
                end else if (bal_n <= BAL_W'(LOSS_THRESH)) begin
                    state_n = S_OVER;
                    loss_n  = 1'b1;
                    dig_n   = '0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_OVER: ;
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n == S_SPIN) || (state_n == S_WILD) || (state_n == S_SCORE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            wcnt_q   <= '0;
            dig_q    <= '0;
            snap_q   <= '0;
            bet_q    <= '0;
            bal_q    <= BAL_W'(BAL_INIT);
            locked_q <= '0;
            wild_q   <= '0;
            wact_q   <= '0;
            pv_q     <= 1'b0;
            err_q    <= 1'b0;
            win_q    <= 1'b0;
            loss_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            step_q   <= step_n;
            wcnt_q   <= wcnt_n;
            dig_q    <= dig_n;
            snap_q   <= snap_n;
            bet_q    <= bet_n;
            bal_q    <= bal_n;
            locked_q <= locked_n;
            wild_q   <= wild_n;
            wact_q   <= wact_n;
            pv_q     <= pv_n;
            err_q    <= err_n;
            win_q    <= win_n;
            loss_q   <= loss_n;
            busy_q   <= busy_n;
        end
    end

    assign bus.digits       = dig_q;
    assign bus.balance      = bal_q;
    assign bus.busy         = busy_q;
    assign bus.wild_active  = wact_q;
    assign bus.payout_valid = pv_q;
    assign bus.bet_err      = err_q;
    assign bus.game_win     = win_q;
    assign bus.game_loss    = loss_q;
endmodule

// File: tb/tb_slot_reel_engine.sv
// Self-checking bench for slot_reel_engine: directed rounds plus randomized rounds
// scored by a histogram-based payout model.
module tb_slot_reel_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    slot_reel_if #(.N_REELS(4), .SYM_W(4), .BAL_W(16)) bus ();
    slot_reel_if #(.N_REELS(6), .SYM_W(4), .BAL_W(12)) bus2 ();

    slot_reel_engine #(.SPIN_CYCLES(20), .STAGGER_CYCLES(5), .STEP_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    slot_reel_engine #(.N_REELS(6), .BAL_W(12), .BAL_INIT(4000), .WIN_THRESH(4095),
                       .SPIN_CYCLES(20), .STAGGER_CYCLES(5), .STEP_CYCLES(4)) dut_big (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int n_chk = 0;
    int n_err = 0;
    int m_bal = 1000;
    bit m_over = 1'b0;
    int rng_v[4];
    int tgt_v[4];
    int fin_v[4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pack_rng();
        logic [15:0] p;
        for (int i = 0; i < 4; i++) p[i*4 +: 4] = 4'(rng_v[i]);
        return p;
    endfunction

    function automatic logic [15:0] pack_fin();
        logic [15:0] p;
        for (int i = 0; i < 4; i++) p[i*4 +: 4] = 4'(fin_v[i]);
        return p;
    endfunction

    // Best match count from a symbol histogram of the final reel values.
    function automatic int best_match();
        int h[16];
        int k;
        k = 0;
        for (int s = 0; s < 16; s++) h[s] = 0;
        for (int i = 0; i < 4; i++) h[fin_v[i]]++;
        for (int s = 0; s < 16; s++) if (h[s] > k) k = h[s];
        return k;
    endfunction

    task automatic do_reset();
        bus.roll = 1'b0; bus.stop = 1'b0; bus.bet = '0; bus.rng_in = '0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_balance", bus.balance, 1000);
        chk("rst_digits", bus.digits, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wild", bus.wild_active, 0);
        chk("rst_payout", bus.payout_valid, 0);
        chk("rst_flags", {bus.game_win, bus.game_loss, bus.bet_err}, 0);
        rst = 1'b1;
        m_bal = 1000;
        m_over = 1'b0;
    endtask

    task automatic round(input int b);
        bit acc, wild_any;
        logic [3:0] wq;
        logic [15:0] exp_dig;
        int cyc, k, nb, nxt;
        acc = (b >= 1) && (b <= m_bal);
        wild_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wq[i] = (rng_v[i] >= 10);
            fin_v[i] = wq[i] ? tgt_v[i] : rng_v[i];
            if (wq[i]) wild_any = 1'b1;
        end
        @(negedge clk);
        bus.roll = 1'b1; bus.bet = 16'(b); bus.rng_in = pack_rng();
        @(negedge clk);
        bus.roll = 1'b0; bus.rng_in = 16'($urandom);
        if (!acc) begin
            chk("bet_err", bus.bet_err, 1);
            chk("err_balance", bus.balance, 64'(m_bal));
            chk("err_busy", bus.busy, 0);
            @(negedge clk);
            chk("bet_err_pulse", bus.bet_err, 0);
            return;
        end
        chk("busy", bus.busy, 1);
        cyc = 0;
        while (!bus.payout_valid && cyc < 2000) begin
            bus.stop = 1'b0;
            if (bus.wild_active != '0) begin
                nxt = 0;
                for (int i = 3; i >= 0; i--) if (wq[i]) nxt = i;
                if (bus.digits[nxt*4 +: 4] == 4'(tgt_v[nxt])) begin
                    chk("wild_active", bus.wild_active, 64'(1 << nxt));
                    wq[nxt] = 1'b0;
                    bus.stop = 1'b1;
                end
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.stop = 1'b0;
        chk("payout_seen", bus.payout_valid, 1);
        if (!bus.payout_valid) return;
        if (!wild_any) chk("latency", 64'(cyc), 37);
        k = best_match();
        nb = (k == 1) ? m_bal - b : m_bal + b * ((k == 4) ? 15 : (k == 3) ? 7 : 2);
        if (nb > 65535) nb = 65535;
        m_bal = nb;
        exp_dig = pack_fin();
        if (nb >= 1500) exp_dig = 16'h9999;
        else if (nb <= 500) exp_dig = 16'h0000;
        m_over = (nb >= 1500) || (nb <= 500);
        chk("balance", bus.balance, 64'(nb));
        chk("digits", bus.digits, 64'(exp_dig));
        chk("game_win", bus.game_win, 64'(nb >= 1500));
        chk("game_loss", bus.game_loss, 64'(nb > 0 && nb <= 500 || nb == 0));
        chk("busy_done", bus.busy, 0);
        @(negedge clk);
        chk("payout_pulse", bus.payout_valid, 0);
    endtask

    // Once the game is over, roll and stop must have no effect.
    task automatic over_ignored(input logic [15:0] exp_dig);
        @(negedge clk);
        bus.roll = 1'b1; bus.stop = 1'b1; bus.bet = 16'd1;
        @(negedge clk);
        bus.roll = 1'b0; bus.stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("over_busy", bus.busy, 0);
        chk("over_balance", bus.balance, 64'(m_bal));
        chk("over_digits", bus.digits, 64'(exp_dig));
    endtask

    task automatic abort_test(input bit in_wild);
        int cyc;
        if (in_wild) rng_v = '{10, 1, 2, 3}; else rng_v = '{1, 2, 3, 4};
        @(negedge clk);
        bus.roll = 1'b1; bus.bet = 16'd100; bus.rng_in = pack_rng();
        @(negedge clk);
        bus.roll = 1'b0;
        cyc = 0;
        if (in_wild) begin
            while (bus.wild_active == '0 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("abort_in_wild", bus.wild_active, 1);
        end else begin
            repeat (10) @(negedge clk);
            chk("abort_in_spin", bus.busy, 1);
        end
        do_reset();
    endtask

    task automatic big_test();
        int cyc, exp;
        chk("big_init", bus2.balance, 4000);
        @(negedge clk);
        bus2.roll = 1'b1; bus2.bet = 12'd900; bus2.rng_in = {6{4'd2}};
        @(negedge clk);
        bus2.roll = 1'b0;
        cyc = 0;
        while (!bus2.payout_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        exp = 4000 + 900 * 15;
        if (exp > 4095) exp = 4095;
        chk("big_payout", bus2.payout_valid, 1);
        chk("big_balance", bus2.balance, 64'(exp));
        chk("big_win", bus2.game_win, 1);
    endtask

    initial begin
        int b, sel;
        bus2.roll = 1'b0; bus2.stop = 1'b0; bus2.bet = '0; bus2.rng_in = '0;
        do_reset();

        // All-match jackpot, then game over.
        rng_v = '{3, 3, 3, 3};
        round(100);
        over_ignored(16'h9999);

        do_reset();
        rng_v = '{1, 2, 3, 4};
        round(100);
        round(950);

        do_reset();
        rng_v = '{10, 5, 10, 5};
        tgt_v = '{5, 0, 5, 0};
        round(100);

        do_reset();
        rng_v = '{7, 7, 2, 9};
        round(100);
        rng_v = '{0, 1, 2, 3};
        round(400);
        rng_v = '{4, 5, 6, 7};
        round(400);
        over_ignored(16'h0000);

        do_reset();
        abort_test(1'b0);
        abort_test(1'b1);

        big_test();

        do_reset();
        for (int r = 0; r < 30; r++) begin
            if (m_over) do_reset();
            for (int i = 0; i < 4; i++) begin
                rng_v[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 15))
                                                       : int'($urandom_range(0, 9));
                tgt_v[i] = int'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 2) == 0) rng_v[1] = rng_v[0];
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      b = 0;
            else if (sel == 1) b = m_bal + int'($urandom_range(1, 50));
            else if (sel == 2) b = m_bal;
            else               b = int'($urandom_range(1, m_bal / 4 + 1));
            round(b);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/slot_reel_engine.md
Name: slot_reel_engine

Overview:
Parametrised slot-machine game core. It supports N reels, a configurable symbol alphabet and wildcard code, staggered left-to-right reel stops, sequential player-stopped wildcards, and a generic match-count payout rule. It sits between the RNG, keypad and bet logic on one side and the seven-segment driver on the other. It owns the reel digits, the balance and the win/loss status.

Parameters:
N_REELS, 4, number of reels (2..8)
SYM_W, 4, bits per reel symbol
N_SYMBOLS, 10, displayable symbols 0..N_SYMBOLS-1
WILD_CODE, 10, RNG code marking a wildcard reel (must be >= N_SYMBOLS)
SPIN_CYCLES, 300000000, cycles before reel 0 locks
STAGGER_CYCLES, 50000000, extra cycles between successive reel locks
STEP_CYCLES, 10000000, base animation step period
BAL_W, 16, balance width
BAL_INIT, 1000, balance after reset
WIN_THRESH, 1500, balance >= this sets game_win
LOSS_THRESH, 500, balance <= this sets game_loss
PAY2, 2, multiplier for best match of 2
PAY3, 7, multiplier for best match of 3..N_REELS-1
PAYALL, 15, multiplier when all reels match

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
roll  in  1  one-cycle roll request (already edge-detected)
stop  in  1  one-cycle wildcard stop request
bet  in  BAL_W  bet amount, sampled on accepted roll
rng_in  in  N_REELS*SYM_W  reel results, reel i at [i*SYM_W +: SYM_W]
digits  out  N_REELS*SYM_W  displayed reel values, same packing
balance  out  BAL_W  current balance
busy  out  1  high in any state except IDLE and OVER
wild_active  out  N_REELS  one-hot: the reel awaiting stop
payout_valid  out  1  one-cycle pulse when balance is updated
bet_err  out  1  one-cycle pulse when a roll is rejected
game_win  out  1  sticky
game_loss  out  1  sticky

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE, digits=0, balance=BAL_INIT, all flags/pulses 0, all counters 0.
  - Reset mid-operation aborts the round without any balance change.
- States: IDLE, SPIN, WILD, SCORE, OVER.
- IDLE:
  - roll with 1<=bet<=balance: latch bet and rng_in snapshot, clear spin counter, go to SPIN next cycle.
  - roll with bet==0 or bet>balance: bet_err pulse next cycle, stay IDLE, no other change.
  - stop is ignored.
- SPIN:
  - Counter increments each cycle.
  - Unlocked reel i advances (d+1) mod N_SYMBOLS every STEP_CYCLES+i*(STEP_CYCLES/4) cycles.
  - Reel i locks on the cycle counter == SPIN_CYCLES+i*STAGGER_CYCLES.
    - Non-wild snapshot: digit = snapshot value.
    - Snapshot == WILD_CODE: marks wild, digit=0.
    - Snapshot otherwise >= N_SYMBOLS: treated as wild.
  - After the last reel locks: any wild -> WILD with lowest wild index active; else -> SCORE.
  - roll and stop are ignored during SPIN.
- WILD:
  - Active reel digit steps mod N_SYMBOLS every STEP_CYCLES.
  - stop freezes the current value the same cycle and clears its wild bit.
  - Next-higher wild reel becomes active the following cycle; a new roll is ignored.
  - After the last wild is stopped -> SCORE.
- SCORE (exactly one cycle):
  - k = largest count of equal digits across reels.
  - k==N_REELS -> balance += bet*PAYALL
  - 3<=k<N_REELS -> += bet*PAY3
  - k==2 -> += bet*PAY2
  - k==1 -> -= bet
  - Products are computed at BAL_W+8 bits; a result above 2^BAL_W-1 saturates; subtraction cannot underflow (bet<=balance).
  - payout_valid pulses this cycle.
  - Next state is OVER if the new balance >= WIN_THRESH (game_win=1) or <= LOSS_THRESH (game_loss=1); otherwise IDLE. Win takes priority if both hold.
  - For N_REELS==2, k==2 means all reels match and pays PAYALL.
- OVER: digits forced to all N_SYMBOLS-1 (win) or all 0 (loss); roll and stop ignored until reset.
- Latency: roll-accept to SCORE = SPIN_CYCLES+(N_REELS-1)*STAGGER_CYCLES+2 cycles with no wilds.

Test Plan (bench uses SPIN_CYCLES=20, STAGGER_CYCLES=5, STEP_CYCLES=4, defaults otherwise):
- Reset, roll, bet=100, rng 3,3,3,3 -> lock times 20/25/30/35, payout_valid at roll+37, balance=2500, game_win=1, digits all 9, roll then ignored.
- rng 1,2,3,4, bet=100 -> balance 900, state IDLE, busy=0; bet=950 with balance 900 -> bet_err pulse, balance unchanged.
- rng 10,5,10,5, bet=100 -> wild_active=0001; stop when digit0=5 -> wild_active=0100; stop when digit2=5 -> all-match, balance=2500.
- rng 7,7,2,9, bet=100 -> k=2, balance=1200; repeated no-match rolls at bet=400 -> 800 then 400, game_loss=1, digits 0.
- N_REELS=6, BAL_W=12, BAL_INIT=4000, WIN_THRESH=4095, all-match at bet=900 -> balance saturates at 4095, game_win=1.
- Assert rst=0 during SPIN and during WILD -> next cycle balance=1000, IDLE, digits 0, no payout_valid.
